// File: rtl/ball_pair_scheduler_if.sv
// ball_pair_scheduler_if
// Bundles the scheduler's frame-request, datapath-select and status signals.
//
// Parameter:
//   IDX_W              width of the ball index selects; must equal $clog2(NUM_BALLS)
//                      of the scheduler the bundle is connected to
// Signals:
//   startOfFrame       frame-timing -> scheduler, one-cycle sweep request
//   collisionOccurred  ball_collision -> scheduler, collision flag of the pair in flight
//   pairSelA/pairSelB  scheduler -> index muxes, current pair (A < B while busy)
//   pairValid          scheduler -> datapath, new pair presented this cycle
//   writeEnable        scheduler -> velocity registers, commit new velocities of A and B
//   busy               scheduler status, sweep in progress
//   frameDone          scheduler status, one-cycle end-of-sweep pulse
//   overrun            scheduler status, sticky "request arrived while sweeping"
//   collisionCount     collisions seen in the current/last sweep
//                      (present only when COLLISION_COUNT_EN is defined)
// Modports: master = scheduler side, slave = surrounding logic side.
interface ball_pair_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             startOfFrame;
  logic             collisionOccurred;
  logic [IDX_W-1:0] pairSelA;
  logic [IDX_W-1:0] pairSelB;
  logic             pairValid;
  logic             writeEnable;
  logic             busy;
  logic             frameDone;
  logic             overrun;
`ifdef COLLISION_COUNT_EN
  logic [7:0]       collisionCount;
`endif

  modport master (
    input  startOfFrame,
    input  collisionOccurred,
    output pairSelA,
    output pairSelB,
    output pairValid,
    output writeEnable,
    output busy,
    output frameDone,
`ifdef COLLISION_COUNT_EN
    output collisionCount,
`endif
    output overrun
  );

  modport slave (
    output startOfFrame,
    output collisionOccurred,
    input  pairSelA,
    input  pairSelB,
    input  pairValid,
    input  writeEnable,
    input  busy,
    input  frameDone,
`ifdef COLLISION_COUNT_EN
    input  collisionCount,
`endif
    input  overrun
  );
endinterface

// File: rtl/ball_pair_scheduler.sv
// ball_pair_scheduler
// Time-shares one pairwise ball_collision datapath among NUM_BALLS balls.
// Each accepted startOfFrame walks every unordered pair (i<j) in lexical order:
// one ISSUE cycle presents the pair (pairValid), PAIR_LATENCY WAIT cycles hold
// it stable, and in the last WAIT cycle writeEnable follows collisionOccurred.
// After the last pair a single DONE cycle pulses frameDone.
//
// Parameters:
//   NUM_BALLS     number of balls (>= 2)
//   PAIR_LATENCY  datapath latency in cycles from pairValid (>= 1)
// Ports:
//   clk           rising-edge system clock
//   reset         synchronous active-high reset; aborts any sweep in progress
//   bus           ball_pair_scheduler_if master modport (see the interface file)
// Optional feature:
//   COLLISION_COUNT_EN  when defined, adds an 8-bit saturating per-sweep
//                       collision counter on bus.collisionCount
module ball_pair_scheduler #(
  parameter int NUM_BALLS    = 4,
  parameter int PAIR_LATENCY = 1
) (
  input logic                    clk,
  input logic                    reset,
  ball_pair_scheduler_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_BALLS);
  localparam int WAIT_W = (PAIR_LATENCY > 1) ? $clog2(PAIR_LATENCY) : 1;

  localparam logic [IDX_W-1:0]  LAST_J    = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0]  LAST_I    = IDX_W'(NUM_BALLS - 2);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PAIR_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  sel_a_reg, sel_a_next;
  logic [IDX_W-1:0]  sel_b_reg, sel_b_next;
  logic [WAIT_W-1:0] wait_reg,  wait_next;
  logic              overrun_reg, overrun_next;
  logic              write_en;
  logic              sof_accept;

`ifdef COLLISION_COUNT_EN
  logic [7:0]        count_reg, count_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      sel_a_reg   <= '0;
      sel_b_reg   <= '0;
      wait_reg    <= '0;
      overrun_reg <= 1'b0;
`ifdef COLLISION_COUNT_EN
      count_reg   <= 8'd0;
`endif
    end else begin
      state_reg   <= state_next;
      sel_a_reg   <= sel_a_next;
      sel_b_reg   <= sel_b_next;
      wait_reg    <= wait_next;
      overrun_reg <= overrun_next;
`ifdef COLLISION_COUNT_EN
      count_reg   <= count_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_a_next   = sel_a_reg;
    sel_b_next   = sel_b_reg;
    wait_next    = wait_reg;
    overrun_next = overrun_reg;
    write_en     = 1'b0;
    sof_accept   = 1'b0;

    // A request while a sweep (or its DONE cycle) is in flight is dropped
    // but remembered until reset so the frame logic can detect it.
    if (bus.startOfFrame && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.startOfFrame) begin
          sof_accept = 1'b1;
          state_next = ISSUE;
          sel_a_next = '0;
          sel_b_next = IDX_W'(1);
        end
      end

      ISSUE: begin
        state_next = WAIT;
        wait_next  = WAIT_LOAD;
      end

      WAIT: begin
        if (wait_reg == '0) begin
          // Datapath result is valid only now; earlier flags are ignored.
          write_en = bus.collisionOccurred;
          if (sel_b_reg < LAST_J) begin
            sel_b_next = sel_b_reg + IDX_W'(1);
            state_next = ISSUE;
          end else if (sel_a_reg < LAST_I) begin
            // i < NUM_BALLS-2 here, so i+2 never exceeds NUM_BALLS-1.
            sel_a_next = sel_a_reg + IDX_W'(1);
            sel_b_next = sel_a_reg + IDX_W'(2);
            state_next = ISSUE;
          end else begin
            state_next = DONE;
          end
        end else begin
          wait_next = wait_reg - WAIT_W'(1);
        end
      end

      DONE: begin
        // Selects deliberately keep the last pair.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef COLLISION_COUNT_EN
  always_comb begin
    count_next = count_reg;
    if (sof_accept) begin
      count_next = 8'd0;
    end else if (write_en && (count_reg != 8'hFF)) begin
      count_next = count_reg + 8'd1;
    end
  end

  assign bus.collisionCount = count_reg;
`endif

  assign bus.pairSelA    = sel_a_reg;
  assign bus.pairSelB    = sel_b_reg;
  assign bus.pairValid   = (state_reg == ISSUE);
  assign bus.writeEnable = write_en;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.frameDone   = (state_reg == DONE);
  assign bus.overrun     = overrun_reg;

endmodule
